load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between execute and data_memory (word-wide, 1-cycle registered read, no byte enables).
//  Accepts one load/store request at a time via valid/ready and drives the memory's single port.
//  Implements LB/LH/LW/LBU/LHU and SB/SH/SW; sub-word stores use read-modify-write.
//  Returns a one-cycle response pulse with load data or a fault flag.
// PARAMETERS
//  ADDR_W   5    word-address width of data_memory (depth = 2**ADDR_W words)
//  XLEN     32   data width; only 32 supported
// PORTS
//  clk            in   1       clock, all logic on posedge
//  rst            in   1       synchronous, active-low reset
//  req_valid      in   1       request present
//  req_ready      out  1       LSU idle, request accepted when valid&&ready
//  req_we         in   1       1=store, 0=load
//  req_funct3     in   3       RV32I load/store funct3
//  req_addr       in   32      byte address
//  req_wdata      in   32      store data (rs2)
//  rsp_valid      out  1       one-cycle completion pulse, no backpressure
//  rsp_rdata      out  32      extended load data (0 for stores/faults)
//  rsp_fault      out  1       illegal funct3 or misaligned (see CONFIGURATION)
//  mem_wr_rd_en   out  1       to data_memory: 1=write, 0=read
//  mem_addr       out  ADDR_W  word index = addr_q[ADDR_W+1:2]; upper bits ignored (wrap)
//  mem_write_data out  32      word to write
//  mem_read_data  in   32      registered read word from data_memory
// BEHAVIOUR
//  Reset (rst=0): state IDLE; rsp_valid/rsp_fault=0, rsp_rdata=0; mem_wr_rd_en=0,
//   mem_addr=0, mem_write_data=0 forced that same cycle (a pending WRITE is dropped).
//  Request latched into addr_q/f3_q/we_q/wdata_q on accept; req_ready=1 only in IDLE.
//  States: IDLE, READ, CAPT, WRITE, RESP.
//   IDLE : fault -> RESP(fault=1); SW -> WRITE; load or SB/SH -> READ.
//   READ : mem_wr_rd_en=0, mem_addr=index -> CAPT.
//   CAPT : mem_read_data valid; load: extract+extend into rdata_q -> RESP;
//          SB/SH: merge lane of wdata_q into word, hold in wdata_q -> WRITE.
//   WRITE: mem_wr_rd_en=1, mem_write_data=wdata_q -> RESP.
//   RESP : rsp_valid=1 for exactly one cycle -> IDLE (next request accepted the following cycle).
//  Outside WRITE: mem_wr_rd_en=0, mem_write_data=0. mem_addr holds index from READ to WRITE.
//  Latency, accept cycle = 0: fault rsp@1; SW rsp@2; loads rsp@3; SB/SH rsp@4.
//  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only). 011/110/111, and 1xx on stores,
//   are illegal -> fault, no memory access, regardless of macro.
//  Lanes: byte lane = addr[1:0], half lane = addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
//  Misaligned: H with addr[0]=1, W with addr[1:0]!=0.
// CONFIGURATION
//  LSU_MISALIGN_FAULT_EN defined: misaligned request -> rsp_fault=1 @ cycle 1, no memory access.
//  Undefined: misaligned allowed; offending low bits truncated (H uses addr[1], W uses addr[1:0]=0),
//   access proceeds normally, rsp_fault set only for illegal funct3.
// STRUCTURE
//  lsu_pkg: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), lsu_state_t enum.
//  Sub-module lsu_lane_align (combinational): load extract/extend and store lane merge.
// TESTING
//  SW addr 0x08 data 0xCAFEBABE; then LW 0x08 -> write at word 2 @cycle1, rsp_rdata=0xCAFEBABE.
//  Word 3 = 0x11223344; SB 0x0E data 0xAA -> word 3 becomes 0x11AA3344, rsp@4.
//  Word 4 = 0x8000F0FF; LB 0x10 -> 0xFFFFFFFF; LBU 0x10 -> 0x000000FF; LH 0x12 -> 0xFFFF8000.
//  LW 0x05: with LSU_MISALIGN_FAULT_EN -> rsp_fault=1 @cycle1, mem_wr_rd_en never 1;
//   without -> reads word 1, no fault.
//  funct3=011 load -> rsp_fault=1, rsp_rdata=0; SH with funct3=101 -> fault, no write.
//  rst=0 asserted while in WRITE -> mem_wr_rd_en=0 that cycle, memory unchanged, state IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings,
// controller state encoding and request-decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPT,
        ST_WRITE,
        ST_RESP
    } lsu_state_t;

    // Encodings with no RV32I meaning, plus unsigned variants on stores.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    endfunction

    // Halfword on an odd address, or word off a 4-byte boundary.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts and extends load data from a memory
// word, and merges a byte/half of store data into a word for read-modify-write.
// Halfword lane is chosen by offset[1] alone, so odd halfword addresses fold
// onto the aligned lane.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] read_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Select the addressed byte and half of the read word.
    always_comb begin
        lane_byte = read_word[7:0];
        case (offset)
            2'd0:    lane_byte = read_word[7:0];
            2'd1:    lane_byte = read_word[15:8];
            2'd2:    lane_byte = read_word[23:16];
            default: lane_byte = read_word[31:24];
        endcase
        lane_half = offset[1] ? read_word[31:16] : read_word[15:0];
    end

    // Sign- or zero-extend the selected lane for loads.
    always_comb begin
        load_data = read_word;
        case (funct3)
            F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
            F3_BU:   load_data = {24'h0, lane_byte};
            F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
            F3_HU:   load_data = {16'h0, lane_half};
            default: load_data = read_word;
        endcase
    end

    // Replace the addressed lane of the read word with the store data.
    always_comb begin
        merged_word = read_word;
        if (funct3[1:0] == 2'b00) begin
            case (offset)
                2'd0:    merged_word = {read_word[31:8], store_data[7:0]};
                2'd1:    merged_word = {read_word[31:16], store_data[7:0], read_word[7:0]};
                2'd2:    merged_word = {read_word[31:24], store_data[7:0], read_word[15:0]};
                default: merged_word = {store_data[7:0], read_word[23:0]};
            endcase
        end else if (funct3[1:0] == 2'b01) begin
            merged_word = offset[1] ? {store_data[15:0], read_word[15:0]}
                                    : {read_word[31:16], store_data[15:0]};
        end else begin
            merged_word = store_data;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a single-port, word-wide data memory
// with a registered read. Sub-word stores are done as read-modify-write.
// Optional feature: define LSU_MISALIGN_FAULT_EN to fault misaligned accesses
// instead of truncating the offending low address bits.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_fault,
    output logic              mem_wr_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_write_data,
    input  logic [XLEN-1:0]   mem_read_data
);

    localparam int unsigned AQ_W = ADDR_W + 2;

    lsu_state_t      state;
    lsu_state_t      state_next;
    logic [AQ_W-1:0] addr_q;
    logic [2:0]      f3_q;
    logic            we_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic            fault_q;
    logic            accept;
    logic            req_fault;
    logic [31:0]     load_data;
    logic [31:0]     merged_word;
    logic            unused_addr_hi;

    // Address bits above the memory index wrap and are intentionally dropped.
    assign unused_addr_hi = &{1'b0, req_addr[31:AQ_W]};
    assign accept         = req_valid && (state == ST_IDLE);

    // Decide at accept time whether the request completes as a fault.
    always_comb begin
`ifdef LSU_MISALIGN_FAULT_EN
        req_fault = f3_illegal(req_funct3, req_we) || is_misaligned(req_funct3, req_addr[1:0]);
`else
        req_fault = f3_illegal(req_funct3, req_we);
`endif
    end

    lsu_lane_align u_lane_align (
        .funct3      (f3_q),
        .offset      (addr_q[1:0]),
        .read_word   (mem_read_data),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing: full-word stores skip the read phase.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_fault)                             state_next = ST_RESP;
                    else if (req_we && (req_funct3 == F3_W))   state_next = ST_WRITE;
                    else                                       state_next = ST_READ;
                end
            end
            ST_READ:  state_next = ST_CAPT;
            ST_CAPT:  state_next = we_q ? ST_WRITE : ST_RESP;
            ST_WRITE: state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; reset forces the memory port quiet in the same cycle.
    always_comb begin
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_rdata      = '0;
        rsp_fault      = 1'b0;
        mem_wr_rd_en   = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        if (rst) begin
            req_ready = (state == ST_IDLE);
            mem_addr  = addr_q[AQ_W-1:2];
            if (state == ST_WRITE) begin
                mem_wr_rd_en   = 1'b1;
                mem_write_data = wdata_q;
            end
            if (state == ST_RESP) begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_fault = fault_q;
            end
        end
    end

    // Request capture and data path: load result or merged store word in CAPT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q  <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else if (accept) begin
            addr_q  <= req_addr[AQ_W-1:0];
            f3_q    <= req_funct3;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            fault_q <= req_fault;
        end else if (state == ST_CAPT) begin
            if (we_q) wdata_q <= XLEN'(merged_word);
            else      rdata_q <= XLEN'(load_data);
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// requests, scored against a word-array reference model of RV32I load/store.
module tb_load_store_unit;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 32;
`ifdef LSU_MISALIGN_FAULT_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          due;
    } rsp_t;

    typedef struct {
        int idx;
        int due;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = 3'b0;
    logic [31:0]       req_addr = 32'h0;
    logic [31:0]       req_wdata = 32'h0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_fault;
    logic              mem_wr_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_idx = '0;
    logic [31:0]       pre_data = 32'h0;

    logic [31:0] dmem    [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    rsp_t        rsp_q [$];
    wr_t         wr_q  [$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W), .XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_fault      (rsp_fault),
        .mem_wr_rd_en   (mem_wr_rd_en),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Data memory: single port, registered read; preload port used during reset.
    always @(posedge clk) begin
        if (pre_we) dmem[pre_idx] <= pre_data;
        else if (mem_wr_rd_en) dmem[mem_addr] <= mem_write_data;
        mem_read_data <= dmem[mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour: returns expected response and latency, updates ref_mem.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic fault, output int lat);
        int          size;
        int          idx;
        int          off;
        logic [31:0] w;
        logic [31:0] mask;
        logic        illegal;
        logic        mis;
        illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
        size    = 1 << f3[1:0];
        mis     = (addr % size) != 0;
        fault   = illegal || (MIS_EN && mis);
        rdata   = 32'h0;
        lat     = 1;
        if (fault) return;
        idx = int'((addr >> 2) % DEPTH);
        off = int'(addr % 4);
        if (size == 2) off = (off / 2) * 2;
        w = ref_mem[idx];
        if (!we) begin
            lat = 3;
            if (size == 1) begin
                rdata = (w >> (8 * off)) & 32'hFF;
                if (!f3[2] && rdata[7]) rdata = rdata | 32'hFFFFFF00;
            end else if (size == 2) begin
                rdata = (w >> (8 * off)) & 32'hFFFF;
                if (!f3[2] && rdata[15]) rdata = rdata | 32'hFFFF0000;
            end else begin
                rdata = w;
            end
        end else if (size == 4) begin
            lat = 2;
            ref_mem[idx] = wdata;
        end else begin
            lat  = 4;
            mask = ((size == 1) ? 32'hFF : 32'hFFFF) << (8 * off);
            ref_mem[idx] = (w & ~mask) | ((wdata << (8 * off)) & mask);
        end
    endtask

    // Present one request, push expectations once it is accepted.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit use_exp,
                         input logic [31:0] exp_rd, input logic exp_f);
        logic [31:0] m_rd;
        logic        m_f;
        int          lat;
        int          waited;
        rsp_t        r;
        wr_t         wr;
        waited = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL req_ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
            req_valid = 1'b0;
            return;
        end
        model(we, f3, addr, wdata, m_rd, m_f, lat);
        r.rdata = use_exp ? exp_rd : m_rd;
        r.fault = use_exp ? exp_f : m_f;
        r.due   = cyc + lat;
        rsp_q.push_back(r);
        if (we && !m_f) begin
            wr.idx = int'((addr >> 2) % DEPTH);
            wr.due = cyc + lat - 1;
            wr_q.push_back(wr);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    // Monitor: score every response pulse and every memory write.
    always @(negedge clk) begin
        rsp_t r;
        wr_t  w;
        if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", cyc);
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, r.rdata);
                chk("rsp_fault", 32'(rsp_fault), 32'(r.fault));
                chk("rsp_latency", 32'(cyc), 32'(r.due));
            end
        end
        if (mem_wr_rd_en) begin
            if (wr_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got write to %0d expected none (cycle %0d)", mem_addr, cyc);
            end else begin
                w = wr_q.pop_front();
                chk("wr_index", 32'(mem_addr), 32'(w.idx));
                chk("wr_cycle", 32'(cyc), 32'(w.due));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        we;
        int          waited;

        // Preload memory under reset with random words plus directed contents.
        for (int i = 0; i < int'(DEPTH); i++) begin
            v = $urandom;
            if (i == 3) v = 32'h11223344;
            if (i == 4) v = 32'h8000F0FF;
            ref_mem[i] = v;
            @(negedge clk);
            pre_we   = 1'b1;
            pre_idx  = ADDR_W'(i);
            pre_data = v;
        end
        @(negedge clk);
        pre_we = 1'b0;
        @(negedge clk);
        chk("reset_mem_wr_rd_en", 32'(mem_wr_rd_en), 32'h0);
        chk("reset_mem_addr", 32'(mem_addr), 32'h0);
        chk("reset_mem_write_data", mem_write_data, 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_fault", 32'(rsp_fault), 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'h1);

        // Directed cases.
        issue(1'b1, 3'b010, 32'h08, 32'hCAFEBABE, 1'b1, 32'h0, 1'b0);
        issue(1'b0, 3'b010, 32'h08, 32'h0, 1'b1, 32'hCAFEBABE, 1'b0);
        issue(1'b1, 3'b000, 32'h0E, 32'h000000AA, 1'b1, 32'h0, 1'b0);
        issue(1'b0, 3'b010, 32'h0C, 32'h0, 1'b1, 32'h11AA3344, 1'b0);
        issue(1'b0, 3'b000, 32'h10, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b0);
        issue(1'b0, 3'b100, 32'h10, 32'h0, 1'b1, 32'h000000FF, 1'b0);
        issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b1, 32'hFFFF8000, 1'b0);
        issue(1'b0, 3'b010, 32'h05, 32'h0, 1'b1, MIS_EN ? 32'h0 : ref_mem[1], MIS_EN);
        issue(1'b0, 3'b011, 32'h00, 32'h0, 1'b1, 32'h0, 1'b1);
        issue(1'b1, 3'b101, 32'h10, 32'h12345678, 1'b1, 32'h0, 1'b1);

        // Reset while the unit is driving a write: the write must be dropped.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h14;
        req_wdata  = 32'hDEADBEEF;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("rstw_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rstw_mem_wr_rd_en", 32'(mem_wr_rd_en), 32'h0);
        chk("rstw_mem_addr", 32'(mem_addr), 32'h0);
        chk("rstw_mem_write_data", mem_write_data, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_idle", 32'(req_ready), 32'h1);
        chk("rstw_no_rsp", 32'(rsp_valid), 32'h0);

        // Randomized traffic, biased toward legal aligned accesses.
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: f3 = 3'b000;
                1: f3 = 3'b001;
                2: f3 = 3'b010;
                3: f3 = 3'b100;
                4: f3 = 3'b101;
                default: f3 = 3'($urandom_range(0, 7));
            endcase
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) addr[0] = 1'b0;
                if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(we, f3, addr, $urandom, 1'b0, 32'h0, 1'b0);
        end

        // Drain, then compare final memory contents with the model.
        waited = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'h0);
        chk("wr_queue_drained", 32'(wr_q.size()), 32'h0);
        @(negedge clk);
        for (int i = 0; i < int'(DEPTH); i++) begin
            chk($sformatf("mem_word_%0d", i), dmem[i], ref_mem[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
